// File: rtl/controlador_cubos.sv
// controlador_cubos: game-level scheduler for a pool of falling cubes.
// Decides when each cube slot launches and where it starts horizontally,
// sets the shared fall speed from the level, and keeps the score.
//
// Ports:
//   clk                  system clock
//   reset                asynchronous active-low reset
//   iniciar              start-game request
//   colision             player/cube collision, ends the game
//   pixel_x, pixel_y     current VGA scan position (frame tick source)
//   terminado_cubos      per-slot "cube finished" flags
//   start_cubos          one-hot, single-cycle launch pulse
//   posicion_x_aleatoria x start of the launched cube (held until next launch)
//   velocidad_cubo       shared fall speed, 1..3
//   puntaje              finished-cube count, saturating at 255
//   jugando              game running
//   juego_terminado      game over
//
// state      | meaning
// E_ESPERA   | idle after reset, waiting for iniciar
// E_JUGANDO  | game running: launches, scoring, levels
// E_FIN      | game over, score frozen, waiting for iniciar
module controlador_cubos #(
    parameter int          NUM_CUBOS          = 4,
    parameter int          FRAMES_ENTRE_CUBOS = 45,
    parameter int          CUBOS_POR_NIVEL    = 8,
    parameter logic [8:0]  LFSR_SEMILLA       = 9'h1A5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 colision,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic [NUM_CUBOS-1:0] terminado_cubos,
    output logic [NUM_CUBOS-1:0] start_cubos,
    output logic [8:0]           posicion_x_aleatoria,
    output logic [1:0]           velocidad_cubo,
    output logic [7:0]           puntaje,
    output logic                 jugando,
    output logic                 juego_terminado
);

    typedef enum logic [1:0] {
        E_ESPERA  = 2'd0,
        E_JUGANDO = 2'd1,
        E_FIN     = 2'd2
    } estado_t;

    localparam logic [7:0] TIMER_FIN    = 8'(FRAMES_ENTRE_CUBOS - 1);
    localparam logic [7:0] PUNTOS_NIVEL = 8'(CUBOS_POR_NIVEL);

    estado_t              estado, estado_n;
    logic [8:0]           lfsr;
    logic                 cond_q;
    logic [NUM_CUBOS-1:0] term_q;
    logic [NUM_CUBOS-1:0] ocupado, ocupado_n;
    logic [7:0]           timer, timer_n;
    logic [1:0]           nivel, nivel_n;
    logic [7:0]           pts_nivel, pts_nivel_n;
    logic [NUM_CUBOS-1:0] start_n;
    logic [8:0]           pos_n;
    logic [7:0]           puntaje_n;

    logic                 cond;
    logic                 tick;
    logic [NUM_CUBOS-1:0] fin;
    logic [7:0]           n_fin;
    logic [NUM_CUBOS-1:0] slot_libre;
    logic                 hay_libre;
    logic [8:0]           suma_puntaje;
    logic [7:0]           suma_nivel;

    // Only the first cycle of the frame-end position counts, however long
    // the scan generator dwells there.
    assign cond      = (pixel_y == 10'd481) && (pixel_x == 10'd0);
    assign tick      = cond && !cond_q;
    assign fin       = terminado_cubos & ~term_q;
    assign hay_libre = ~&ocupado;

    assign jugando         = (estado == E_JUGANDO);
    assign juego_terminado = (estado == E_FIN);

    always_comb begin
        n_fin = '0;
        for (int i = 0; i < NUM_CUBOS; i++) begin
            n_fin = n_fin + 8'(fin[i]);
        end
    end

    // Lowest-index free slot; scanning downwards lets the last hit win.
    always_comb begin
        slot_libre = '0;
        for (int i = NUM_CUBOS - 1; i >= 0; i--) begin
            if (!ocupado[i]) begin
                slot_libre    = '0;
                slot_libre[i] = 1'b1;
            end
        end
    end

    assign suma_puntaje = {1'b0, puntaje} + {1'b0, n_fin};
    assign suma_nivel   = pts_nivel + n_fin;

    always_comb begin
        estado_n    = estado;
        timer_n     = timer;
        // Finishes free their slot in every state: cubes keep falling
        // regardless of the game state.
        ocupado_n   = ocupado & ~fin;
        start_n     = '0;
        pos_n       = posicion_x_aleatoria;
        puntaje_n   = puntaje;
        nivel_n     = nivel;
        pts_nivel_n = pts_nivel;

        case (estado)
            E_ESPERA, E_FIN: begin
                if (iniciar) begin
                    estado_n    = E_JUGANDO;
                    puntaje_n   = '0;
                    nivel_n     = '0;
                    pts_nivel_n = '0;
                    timer_n     = '0;
                end
            end
            E_JUGANDO: begin
                if (colision) begin
                    estado_n = E_FIN;
                end else begin
                    if (tick && (timer < TIMER_FIN)) begin
                        timer_n = timer + 8'd1;
                    end
                    // Launch uses the registered ocupado, so a slot freed
                    // this cycle becomes eligible on the next one.
                    if ((timer == TIMER_FIN) && hay_libre) begin
                        start_n   = slot_libre;
                        pos_n     = lfsr;
                        ocupado_n = ocupado_n | slot_libre;
                        timer_n   = '0;
                    end
                    puntaje_n = suma_puntaje[8] ? 8'hFF : suma_puntaje[7:0];
                    if (suma_nivel >= PUNTOS_NIVEL) begin
                        pts_nivel_n = '0;
                        if (nivel != 2'd2) begin
                            nivel_n = nivel + 2'd1;
                        end
                    end else begin
                        pts_nivel_n = suma_nivel;
                    end
                end
            end
            default: estado_n = E_ESPERA;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado               <= E_ESPERA;
            lfsr                 <= LFSR_SEMILLA;
            cond_q               <= 1'b0;
            term_q               <= '0;
            ocupado              <= '0;
            timer                <= '0;
            nivel                <= '0;
            pts_nivel            <= '0;
            start_cubos          <= '0;
            posicion_x_aleatoria <= '0;
            velocidad_cubo       <= 2'd1;
            puntaje              <= '0;
        end else begin
            estado               <= estado_n;
            // x^9 + x^5 + 1, maximal length, never reaches zero.
            lfsr                 <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
            cond_q               <= cond;
            term_q               <= terminado_cubos;
            ocupado              <= ocupado_n;
            timer                <= timer_n;
            nivel                <= nivel_n;
            pts_nivel            <= pts_nivel_n;
            start_cubos          <= start_n;
            posicion_x_aleatoria <= pos_n;
            velocidad_cubo       <= nivel + 2'd1;
            puntaje              <= puntaje_n;
        end
    end

endmodule
